// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-memory bus and IF/ID latch bundle of the fetch stage
//   master (fetch stage): drives inst_ce_o, inst_addr_o, id_pc_o, id_inst_o, id_valid_o; samples inst_data_i
//   slave  (memory/decode): drives inst_data_i; samples the rest
interface if_fetch_stage_if;
  logic        inst_ce_o;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_data_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  modport master (output inst_ce_o, inst_addr_o, id_pc_o, id_inst_o, id_valid_o, input inst_data_i);
  modport slave  (input inst_ce_o, inst_addr_o, id_pc_o, id_inst_o, id_valid_o, output inst_data_i);
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: owns the PC, fetches from combinational imem and fills the IF/ID latch
//   clk, rst_n (async active-low)
//   stall_i, flush_i, br_taken_i/br_target_i, exc_redirect_i/exc_target_i, halt_i : pipeline control
//   bus (master)   : inst_ce_o/inst_addr_o/inst_data_i imem port, id_pc_o/id_inst_o/id_valid_o IF/ID latch
//   IFETCH_ALIGN_CHECK_EN : adds fetch_adel_o/fetch_badaddr_o and traps misaligned PC loads;
//                           when undefined, loaded PCs are silently word-aligned
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             br_taken_i,
  input  logic [31:0]      br_target_i,
  input  logic             exc_redirect_i,
  input  logic [31:0]      exc_target_i,
  input  logic             halt_i,
`ifdef IFETCH_ALIGN_CHECK_EN
  output logic             fetch_adel_o,
  output logic [31:0]      fetch_badaddr_o,
`endif
  if_fetch_stage_if.master bus
);
  typedef enum logic [1:0] {BOOT, RUN, HALT, ERR} state_t;
  state_t      r_state, w_state;
  logic [31:0] r_pc, r_id_pc, r_id_inst;
  logic        r_id_valid;
  logic [31:0] w_pc, w_tgt, w_ld_pc, w_id_pc, w_id_inst;
  logic        w_id_valid, w_redir, w_adv, w_load, w_keep, w_fetch, w_bad;
`ifdef IFETCH_ALIGN_CHECK_EN
  localparam logic [31:0] BOOT_PC = RESET_PC;
  logic        r_adel;
  logic [31:0] r_badaddr;
`else
  localparam logic [31:0] BOOT_PC = {RESET_PC[31:2], 2'b00};
`endif
  always_comb begin
    w_redir    = exc_redirect_i && r_state != BOOT;
    w_adv      = r_state == RUN && !w_redir && !stall_i && !halt_i;
    w_load     = w_redir || (w_adv && br_taken_i);
    w_tgt      = w_redir ? exc_target_i : br_target_i;
`ifdef IFETCH_ALIGN_CHECK_EN
    w_ld_pc    = w_tgt;
    w_bad      = r_state == BOOT ? |r_pc[1:0] : w_load && |w_tgt[1:0];
`else
    w_ld_pc    = {w_tgt[31:2], 2'b00};
    w_bad      = 1'b0;
`endif
    w_pc       = w_load ? w_ld_pc : w_adv ? r_pc + 32'd4 : r_pc;
    w_state    = w_bad ? ERR :
                 (w_redir || r_state == BOOT) ? RUN :
                 (r_state == RUN && halt_i && !stall_i) ? HALT : r_state;
    // a stall holds the latch unless a flush also bubbles it; everything else not fetching bubbles it
    w_keep     = r_state == RUN && !w_redir && stall_i && !flush_i;
    w_fetch    = w_adv && !flush_i;
    w_id_valid = w_fetch || (w_keep && r_id_valid);
    w_id_pc    = w_fetch ? r_pc : w_keep ? r_id_pc : 32'h0;
    w_id_inst  = w_fetch ? bus.inst_data_i : w_keep ? r_id_inst : NOP_INST;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_pc       <= BOOT_PC;
      r_id_pc    <= 32'h0;
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_id_pc    <= w_id_pc;
      r_id_inst  <= w_id_inst;
      r_id_valid <= w_id_valid;
    end
  end
`ifdef IFETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adel    <= 1'b0;
      r_badaddr <= 32'h0;
    end else begin
      r_adel    <= w_bad;
      r_badaddr <= w_bad ? (r_state == BOOT ? r_pc : w_tgt) : r_badaddr;
    end
  end
  assign fetch_adel_o    = r_adel;
  assign fetch_badaddr_o = r_badaddr;
`endif
  assign bus.inst_ce_o   = r_state == RUN;
  assign bus.inst_addr_o = r_pc;
  assign bus.id_pc_o     = r_id_pc;
  assign bus.id_inst_o   = r_id_inst;
  assign bus.id_valid_o  = r_id_valid;
endmodule
